// File: rtl/keypad_scan.sv
// rtl/keypad_scan.sv - 4x4 key matrix scanner with whole-scan debounce and single-key events
module keypad_scan #(
    parameter int SCAN_DIV       = 50000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] col,
    input  logic [3:0] row,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(DEBOUNCE_SCANS);
    localparam logic [SW-1:0] STABLE_ONE = SW'(1);

    typedef enum logic [1:0] {
        ST_DWELL,
        ST_SAMPLE,
        ST_EVAL
    } state_t;

    typedef enum logic [1:0] {
        CLS_NONE,
        CLS_SINGLE,
        CLS_MULTI
    } cls_t;

    logic [3:0]    row_meta;
    logic [3:0]    row_sync;
    state_t        state;
    logic [1:0]    col_idx;
    logic [DW-1:0] dwell_cnt;
    logic [15:0]   snapshot;
    cls_t          prev_cls;
    logic [3:0]    prev_key;
    logic [SW-1:0] stable_cnt;

    logic [4:0]    bit_cnt;
    logic [3:0]    bit_idx;
    cls_t          cur_cls;
    logic          same_cls;
    logic [SW-1:0] next_cnt;
    logic          accept;
    logic          release_key;

    // Classification of the completed scan; only meaningful in ST_EVAL.
    always_comb begin
        bit_cnt = '0;
        bit_idx = '0;
        for (int i = 0; i < 16; i++) begin
            if (snapshot[i]) begin
                bit_cnt = bit_cnt + 5'd1;
                bit_idx = 4'(i);
            end
        end
        if (bit_cnt == 5'd0) begin
            cur_cls = CLS_NONE;
        end else if (bit_cnt == 5'd1) begin
            cur_cls = CLS_SINGLE;
        end else begin
            cur_cls = CLS_MULTI;
        end
    end

    always_comb begin
        same_cls = (cur_cls == prev_cls) && ((cur_cls != CLS_SINGLE) || (bit_idx == prev_key));
        if (!same_cls) begin
            next_cnt = STABLE_ONE;
        end else if (stable_cnt >= STABLE_MAX) begin
            next_cnt = STABLE_MAX;
        end else begin
            next_cnt = stable_cnt + STABLE_ONE;
        end
        // stable_cnt == 0 marks the reference scan after reset, which never accepts.
        accept = (stable_cnt != '0) && (cur_cls == CLS_SINGLE) && (next_cnt == STABLE_MAX)
                 && (!same_cls || (stable_cnt != STABLE_MAX));
        release_key = key_held && !((cur_cls == CLS_SINGLE) && (bit_idx == key_code));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            row_meta   <= 4'hF;
            row_sync   <= 4'hF;
            state      <= ST_DWELL;
            col_idx    <= 2'd0;
            dwell_cnt  <= '0;
            snapshot   <= '0;
            prev_cls   <= CLS_NONE;
            prev_key   <= 4'd0;
            stable_cnt <= '0;
            col        <= 4'hF;
            key_code   <= 4'd0;
            key_valid  <= 1'b0;
            key_held   <= 1'b0;
        end else begin
            row_meta  <= row;
            row_sync  <= row_meta;
            key_valid <= 1'b0;
            case (state)
                ST_DWELL: begin
                    col <= ~(4'b0001 << col_idx);
                    if (dwell_cnt == DWELL_LAST) begin
                        for (int r = 0; r < 4; r++) begin
                            snapshot[{2'(r), col_idx}] <= ~row_sync[r];
                        end
                        dwell_cnt <= '0;
                        state     <= ST_SAMPLE;
                    end else begin
                        dwell_cnt <= dwell_cnt + 1'b1;
                    end
                end
                ST_SAMPLE: begin
                    if (col_idx == 2'd3) begin
                        state <= ST_EVAL;
                    end else begin
                        col_idx <= col_idx + 2'd1;
                        col     <= ~(4'b0001 << (col_idx + 2'd1));
                        state   <= ST_DWELL;
                    end
                end
                ST_EVAL: begin
                    stable_cnt <= next_cnt;
                    if (!same_cls) begin
                        prev_cls <= cur_cls;
                        prev_key <= bit_idx;
                    end
                    if (accept) begin
                        key_code  <= bit_idx;
                        key_valid <= 1'b1;
                        key_held  <= 1'b1;
                    end else if (release_key) begin
                        key_held <= 1'b0;
                    end
                    col_idx <= 2'd0;
                    col     <= 4'b1110;
                    state   <= ST_DWELL;
                end
                default: begin
                    state <= ST_DWELL;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// tb/tb_keypad_scan.sv - directed bench for keypad_scan with a 4x4 key matrix model
module tb_keypad_scan;

    localparam int SCAN = 21;

    logic        clk;
    logic        reset;
    logic [3:0]  col;
    logic [3:0]  row;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;

    int checks;
    int errors;
    int ev_cnt;
    logic [3:0] ev_code;
    int cyc;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .col       (col),
        .row       (row),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Passive matrix: a pressed key pulls its row low while its column is driven low.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (pressed[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            ev_cnt  = ev_cnt + 1;
            ev_code = key_code;
        end
        checks = checks + 1;
        if ($countones(~col) > 1) begin
            errors = errors + 1;
            $display("FAIL col_onehot: col=%b, required at most one low bit", col);
        end
    end

    task automatic wait_phase(input int ph);
        do @(negedge clk); while ((cyc % SCAN) != ph);
        #1;
    endtask

    task automatic scans(input int n);
        repeat (n) wait_phase(0);
    endtask

    task automatic test_reset;
        logic [3:0] exp_col [5];
        int ph [5];
        exp_col = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
        ph = '{1, 5, 10, 15, 0};
        reset = 1'b0;
        pressed = '0;
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (col !== 4'hF) begin errors = errors + 1; $display("FAIL reset_col: got %b, required 1111", col); end
        checks = checks + 1;
        if (key_valid !== 1'b0) begin errors = errors + 1; $display("FAIL reset_valid: got %b, required 0", key_valid); end
        checks = checks + 1;
        if (key_code !== 4'd0) begin errors = errors + 1; $display("FAIL reset_code: got %0d, required 0", key_code); end
        checks = checks + 1;
        if (key_held !== 1'b0) begin errors = errors + 1; $display("FAIL reset_held: got %b, required 0", key_held); end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_phase(ph[i]);
            checks = checks + 1;
            if (col !== exp_col[i]) begin
                errors = errors + 1;
                $display("FAIL col_seq[%0d]: got %b, required %b", i, col, exp_col[i]);
            end
        end
        scans(10);
        checks = checks + 1;
        if (ev_cnt !== 0) begin errors = errors + 1; $display("FAIL idle_events: got %0d, required 0", ev_cnt); end
    endtask

    task automatic test_single_press;
        int ev0;
        ev0 = ev_cnt;
        pressed = 16'h0200;
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 || key_held !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL single_early: events=%0d held=%b, required %0d/0", ev_cnt - ev0, key_held, 0);
        end
        scans(1);
        checks = checks + 1;
        if (key_valid !== 1'b1 || ev_cnt !== ev0 + 1 || key_code !== 4'd9 || key_held !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_accept: valid=%b events=%0d code=%0d held=%b, required 1/1/9/1",
                     key_valid, ev_cnt - ev0, key_code, key_held);
        end
        @(negedge clk); #1;
        checks = checks + 1;
        if (key_valid !== 1'b0) begin errors = errors + 1; $display("FAIL single_pulse_width: valid=%b, required 0", key_valid); end
        scans(3);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 1 || key_held !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL single_no_repeat: events=%0d held=%b, required 1/1", ev_cnt - ev0, key_held);
        end
        pressed = '0;
        wait_phase(SCAN - 1);
        checks = checks + 1;
        if (key_held !== 1'b1) begin errors = errors + 1; $display("FAIL release_eval_cycle: held=%b, required 1", key_held); end
        wait_phase(0);
        checks = checks + 1;
        if (key_held !== 1'b0 || key_code !== 4'd9) begin
            errors = errors + 1;
            $display("FAIL release: held=%b code=%0d, required 0/9", key_held, key_code);
        end
    endtask

    task automatic test_bounce;
        int ev0;
        scans(1);
        ev0 = ev_cnt;
        for (int i = 0; i < 6; i++) begin
            pressed = (i % 2 == 0) ? 16'h0200 : 16'h0000;
            scans(1);
        end
        checks = checks + 1;
        if (ev_cnt !== ev0) begin errors = errors + 1; $display("FAIL bounce_toggle: events=%0d, required 0", ev_cnt - ev0); end
        pressed = 16'h0200;
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0) begin errors = errors + 1; $display("FAIL bounce_first_steady: events=%0d, required 0", ev_cnt - ev0); end
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 1 || ev_code !== 4'd9) begin
            errors = errors + 1;
            $display("FAIL bounce_accept: events=%0d code=%0d, required 1/9", ev_cnt - ev0, ev_code);
        end
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 1) begin errors = errors + 1; $display("FAIL bounce_saturate: events=%0d, required 1", ev_cnt - ev0); end
        pressed = '0;
        scans(2);
    endtask

    task automatic test_ghosting;
        int ev0;
        ev0 = ev_cnt;
        pressed = 16'h8001;
        scans(5);
        checks = checks + 1;
        if (ev_cnt !== ev0 || key_held !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL multi_no_event: events=%0d held=%b, required 0/0", ev_cnt - ev0, key_held);
        end
        pressed = 16'h0001;
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0) begin errors = errors + 1; $display("FAIL multi_redebounce: events=%0d, required 0", ev_cnt - ev0); end
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 1 || ev_code !== 4'd0 || key_held !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL multi_then_single: events=%0d code=%0d held=%b, required 1/0/1", ev_cnt - ev0, ev_code, key_held);
        end
        pressed = '0;
        scans(2);
    endtask

    task automatic test_key_change;
        int ev0;
        ev0 = ev_cnt;
        pressed = 16'h0008;
        scans(2);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 1 || key_code !== 4'd3 || key_held !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL change_first: events=%0d code=%0d held=%b, required 1/3/1", ev_cnt - ev0, key_code, key_held);
        end
        pressed = 16'h1000;
        scans(1);
        checks = checks + 1;
        if (key_held !== 1'b0 || key_code !== 4'd3 || ev_cnt !== ev0 + 1) begin
            errors = errors + 1;
            $display("FAIL change_between: held=%b code=%0d events=%0d, required 0/3/1", key_held, key_code, ev_cnt - ev0);
        end
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 2 || ev_code !== 4'd12 || key_held !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL change_second: events=%0d code=%0d held=%b, required 2/12/1", ev_cnt - ev0, ev_code, key_held);
        end
        pressed = '0;
        scans(2);
    endtask

    task automatic test_reset_mid;
        int ev0;
        ev0 = ev_cnt;
        pressed = 16'h0040;
        scans(1);
        wait_phase(11);
        reset = 1'b0;
        #1;
        checks = checks + 1;
        if (col !== 4'hF || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'd0) begin
            errors = errors + 1;
            $display("FAIL midreset_outputs: col=%b valid=%b held=%b code=%0d, required 1111/0/0/0",
                     col, key_valid, key_held, key_code);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 || key_held !== 1'b0) begin
            errors = errors + 1;
            $display("FAIL midreset_reference: events=%0d held=%b, required 0/0", ev_cnt - ev0, key_held);
        end
        scans(1);
        checks = checks + 1;
        if (ev_cnt !== ev0 + 1 || ev_code !== 4'd6 || key_held !== 1'b1) begin
            errors = errors + 1;
            $display("FAIL midreset_reaccept: events=%0d code=%0d held=%b, required 1/6/1", ev_cnt - ev0, ev_code, key_held);
        end
        pressed = '0;
        scans(2);
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        ev_cnt  = 0;
        ev_code = 4'd0;
        reset   = 1'b0;
        pressed = '0;
        test_reset();
        test_single_press();
        test_bounce();
        test_ghosting();
        test_key_change();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/keypad_scan.md
# keypad_scan

Scans a 4x4 passive key matrix by driving one column low at a time and reading the row lines. It debounces the result over whole scans and reports each new stable single-key press as a one-cycle event with a 4-bit key code. It is the input-side counterpart of the multiplexed seven-segment driver: that block scans digits out, this block scans keys in. Its `key_code`/`key_valid` pair replaces button-plus-switch loading of the per-digit display registers.

## Interface
- `SCAN_DIV`, default 50000: clock cycles each column is driven (dwell). Minimum 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required before a press is accepted. Minimum 1.

- `clk` input 1: system clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `col` output 4: column drive, active-low. At most one bit is 0 at any time.
- `row` input 4: row sense, active-low (external pull-ups); asynchronous to `clk`.
- `key_code` output 4: code of the last accepted key, `row_idx*4 + col_idx`.
- `key_valid` output 1: one-cycle pulse when `key_code` takes a newly accepted key.
- `key_held` output 1: high while the accepted key is still the stable single key.

## Operation
- `row` passes through a 2-flop synchronizer before any use.
- **Column sequencing**
  - Columns are driven in order 0,1,2,3, then wrap to 0.
  - `col` = ~(1 << col_idx).
  - Dwell counter runs 0..SCAN_DIV-1 per column.
- **Sampling**
  - On dwell count SCAN_DIV-1, the inverted synchronized row is written into a 16-bit snapshot.
  - Bit index = `row_idx*4 + col_idx`.
  - The snapshot for the active column is cleared before its sample is written.
- **FSM states**
  - DWELL: counting. Exits on the last dwell cycle.
  - SAMPLE: capture. Goes to DWELL for the next column, or to EVAL after column 3.
  - EVAL: one cycle. Classifies the snapshot, then goes to DWELL on column 0 with the dwell counter at 0.
  - The column drive is held during SAMPLE and EVAL.
- **Classification (EVAL)**
  - NONE: 0 bits set.
  - SINGLE(k): exactly 1 bit set; k is its index.
  - MULTI: 2 or more bits set.
- **Debounce**
  - If the classification equals the previous scan's (same class, and same k for SINGLE), `stable_cnt` increments, saturating at DEBOUNCE_SCANS.
  - Otherwise `stable_cnt` = 1 and the previous classification is replaced.
- **Accept**
  - Triggered when `stable_cnt` transitions to DEBOUNCE_SCANS and the class is SINGLE(k).
  - Effect: `key_code` ← k, `key_valid` pulses, `key_held` ← 1.
  - Saturated repeats of the same SINGLE(k) do not re-pulse; there is no auto-repeat.
- **Release**
  - `key_held` ← 0 on the first EVAL whose classification differs from the accepted SINGLE(k).
  - This applies for NONE, MULTI, or a different key, with no debounce on release.
  - `key_code` keeps its last value.
- **MULTI** never produces an event. A later SINGLE must be re-debounced from `stable_cnt` = 1.
- **Re-press** of the same key after any intervening different classification produces a new event once stable.

## Timing
- **Reset values** (while `reset` = 0)
  - `col` = 4'b1111, `key_code` = 0, `key_valid` = 0, `key_held` = 0.
  - Snapshot = 0, `stable_cnt` = 0, previous class = NONE.
  - FSM in DWELL, column 0, dwell 0.
- **After reset release**
  - `col` = 4'b1110 from the first rising edge after deassertion.
  - The first scan result is discarded as a debounce reference only: it sets `stable_cnt` = 1 and can never accept on its own, even when DEBOUNCE_SCANS = 1.
- **Reset mid-scan** aborts immediately: all state returns to reset values and no pending event is emitted.
- **Column period** = SCAN_DIV + 1 cycles (plus 1 extra on column 3 for EVAL). Full scan = 4*SCAN_DIV + 5 cycles.
- **Settling:** the sample is taken SCAN_DIV-1 cycles after the column change, which covers the 2-cycle synchronizer plus line settling.
- **Event latency:** `key_valid` is high in the cycle after EVAL of the accepting scan, for exactly 1 cycle. `key_code` is updated in that same cycle and is stable before and after the pulse.
- **Press/release on the same scan:** a key change during a column's dwell is seen only at that column's sample cycle. Changes after the sample land in the next scan.

## Test plan
Parameters: SCAN_DIV=4, DEBOUNCE_SCANS=2; scan = 21 cycles.

1. **Reset/idle.** Hold `reset` low 5 cycles, all rows high.
   - During reset: `col` = 1111, outputs 0.
   - After release: `col` cycles 1110→1101→1011→0111, and `key_valid` never fires over 10 scans.
2. **Single press.** Press row 2/col 1 (row[2] low while col[1] low) for 5 scans.
   - Exactly one `key_valid` with `key_code` = 9.
   - `key_held` = 1 until release; falls 1 cycle after the first NONE EVAL.
3. **Bounce.** Toggle key 9 every other scan for 6 scans, then hold 3 scans.
   - No event during toggling.
   - One event (code 9) at the end of the 2nd steady scan.
4. **Ghosting.** Hold keys 0 and 15 together for 5 scans, then release 15.
   - No event while both are held.
   - Event code 0 after 2 scans of SINGLE(0).
5. **Key change.** Hold key 3 until accepted, then switch directly to key 12.
   - `key_held` drops at the first scan seeing 12.
   - `key_valid` fires with code 12 one scan later; `key_code` reads 3 in between.
6. **Reset mid-debounce.** Assert `reset` during column 2 of the accepting scan.
   - No `key_valid`; outputs return to reset values.
   - After release, the still-held key is re-accepted after 2 full scans.
